// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide first-word-fall-through circular instruction buffer between fetch and decode.
// Defining FETCH_QUEUE_STATS_EN adds saturating full-cycle and flush counters.
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [1:0]              in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_addr_0,
    input  logic [ADDR_WIDTH-1:0]   in_addr_1,
    input  logic [DATA_WIDTH-1:0]   in_instr_0,
    input  logic [DATA_WIDTH-1:0]   in_instr_1,
    output logic                    in_ready,
    output logic [1:0]              out_valid,
    output logic [ADDR_WIDTH-1:0]   out_addr_0,
    output logic [ADDR_WIDTH-1:0]   out_addr_1,
    output logic [DATA_WIDTH-1:0]   out_instr_0,
    output logic [DATA_WIDTH-1:0]   out_instr_1,
    input  logic [1:0]              out_ready,
    output logic [$clog2(DEPTH):0]  count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]             stat_full_cycles,
    output logic [15:0]             stat_flushes
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0] head, tail, head_1, tail_1;
    logic [1:0] enq, deq;

    assign head_1 = head + 1'b1;
    assign tail_1 = tail + 1'b1;
    // Ready depends only on registered occupancy, so a same-cycle dequeue never frees space early.
    assign in_ready = count <= CW'(DEPTH - 2);
    assign out_valid = {count >= CW'(2), count != '0};
    assign enq = !in_ready ? 2'd0 : in_valid == 2'b11 ? 2'd2 : in_valid == 2'b01 ? 2'd1 : 2'd0;
    assign deq = !(out_ready[0] && out_valid[0]) ? 2'd0 : (out_ready[1] && out_valid[1]) ? 2'd2 : 2'd1;
    assign out_addr_0 = out_valid[0] ? addr_mem[head] : '0;
    assign out_addr_1 = out_valid[1] ? addr_mem[head_1] : '0;
    assign out_instr_0 = out_valid[0] ? instr_mem[head] : '0;
    assign out_instr_1 = out_valid[1] ? instr_mem[head_1] : '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            head <= head + PW'(deq);
            tail <= tail + PW'(enq);
            count <= count + CW'(enq) - CW'(deq);
        end

    always_ff @(posedge clk) begin
        if (!flush && enq != 2'd0) begin
            addr_mem[tail] <= in_addr_0;
            instr_mem[tail] <= in_instr_0;
        end
        if (!flush && enq == 2'd2) begin
            addr_mem[tail_1] <= in_addr_1;
            instr_mem[tail_1] <= in_instr_1;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stat_full_cycles <= '0;
            stat_flushes <= '0;
        end else begin
            if (count == CW'(DEPTH) && stat_full_cycles != '1)
                stat_full_cycles <= stat_full_cycles + 1'b1;
            if (flush && stat_flushes != '1)
                stat_flushes <= stat_flushes + 1'b1;
        end
`endif
endmodule
